// File: rtl/dac_processing_pkg.sv
// Shared register map, field layout and FSM encoding for the DAC conditioning block.
package dac_processing_pkg;

  localparam logic [3:0] REG_LIM  = 4'h0;
  localparam logic [3:0] REG_CAL  = 4'h4;
  localparam logic [3:0] REG_SLEW = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int LIM_LOW_LSB   = 0;
  localparam int LIM_HIGH_LSB  = 16;
  localparam int OFFSET_LSB    = 0;
  localparam int CAL_SHIFT_LSB = 16;
  localparam int SLEW_STEP_LSB = 0;
  localparam int RATIO_LSB     = 0;
  localparam int FDELAY_LSB    = 8;
  localparam int CLEAR_BIT     = 16;
  localparam int FDIS_BIT      = 17;
  localparam int SLEW_EN_BIT   = 18;

  typedef enum logic [1:0] {IDLE, CAL, SAT, EMIT} state_t;

  typedef struct packed {
    logic signed [15:0] lim_low;
    logic signed [15:0] lim_high;
    logic signed [15:0] offset;
    logic [2:0]         cal_shift;
    logic [15:0]        slew_step;
    logic [7:0]         interp_ratio;
    logic [7:0]         fault_delay;
    logic               fault_disable;
    logic               slew_enable;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{
    lim_low: 16'sh8000, lim_high: 16'sh7FFF, offset: 16'sd0, cal_shift: 3'd0,
    slew_step: 16'd0, interp_ratio: 8'd1, fault_delay: 8'd0,
    fault_disable: 1'b0, slew_enable: 1'b0
  };

endpackage

// File: rtl/dac_processing_cu.sv
// AXI-lite register file; exposes decoded configuration fields and a clear_fault pulse.
module dac_processing_cu
  import dac_processing_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output cfg_t        cfg,
  output logic        clear_fault
);

  logic        wr_en;
  logic [31:0] rd_val;
  logic        unused_wdata;

  // Address and data are taken together; one write in flight at a time.
  assign wr_en        = awvalid && wvalid && !bvalid;
  assign awready      = wr_en;
  assign wready       = wr_en;
  assign bresp        = 2'b00;
  assign rresp        = 2'b00;
  assign arready      = !rvalid;
  assign unused_wdata = ^wdata[31:19];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cfg         <= CFG_RESET;
      clear_fault <= 1'b0;
      bvalid      <= 1'b0;
    end else begin
      clear_fault <= 1'b0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (wr_en) begin
        bvalid <= 1'b1;
        case (awaddr)
          REG_LIM: begin
            cfg.lim_low  <= wdata[LIM_LOW_LSB +: 16];
            cfg.lim_high <= wdata[LIM_HIGH_LSB +: 16];
          end
          REG_CAL: begin
            cfg.offset    <= wdata[OFFSET_LSB +: 16];
            cfg.cal_shift <= wdata[CAL_SHIFT_LSB +: 3];
          end
          REG_SLEW: cfg.slew_step <= wdata[SLEW_STEP_LSB +: 16];
          REG_CTRL: begin
            cfg.interp_ratio  <= wdata[RATIO_LSB +: 8];
            cfg.fault_delay   <= wdata[FDELAY_LSB +: 8];
            clear_fault       <= wdata[CLEAR_BIT];
            cfg.fault_disable <= wdata[FDIS_BIT];
            cfg.slew_enable   <= wdata[SLEW_EN_BIT];
          end
          default: ;
        endcase
      end
    end
  end

  // clear_fault is a pulse and always reads back as 0.
  always_comb begin
    rd_val = '0;
    case (araddr)
      REG_LIM:  rd_val = {cfg.lim_high, cfg.lim_low};
      REG_CAL:  rd_val = {13'd0, cfg.cal_shift, cfg.offset};
      REG_SLEW: rd_val = {16'd0, cfg.slew_step};
      REG_CTRL: rd_val = {13'd0, cfg.slew_enable, cfg.fault_disable, 1'b0,
                          cfg.fault_delay, cfg.interp_ratio};
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
      end
    end
  end

endmodule

// File: rtl/dac_processing.sv
// DAC setpoint conditioning: calibrate, clamp, slew/interpolate, and saturation fault.
module dac_processing
  import dac_processing_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 16,
  parameter bit STICKY_FAULT    = 1'b0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              data_in_valid,
  output logic                              data_in_ready,
  input  logic signed [DATA_PATH_WIDTH-1:0] data_in_data,
  output logic                              data_out_valid,
  input  logic                              data_out_ready,
  output logic signed [DATA_PATH_WIDTH-1:0] data_out_data,
  input  logic [3:0]                        axi_in_awaddr,
  input  logic                              axi_in_awvalid,
  output logic                              axi_in_awready,
  input  logic [31:0]                       axi_in_wdata,
  input  logic                              axi_in_wvalid,
  output logic                              axi_in_wready,
  output logic [1:0]                        axi_in_bresp,
  output logic                              axi_in_bvalid,
  input  logic                              axi_in_bready,
  input  logic [3:0]                        axi_in_araddr,
  input  logic                              axi_in_arvalid,
  output logic                              axi_in_arready,
  output logic [31:0]                       axi_in_rdata,
  output logic [1:0]                        axi_in_rresp,
  output logic                              axi_in_rvalid,
  input  logic                              axi_in_rready,
  output logic                              fault
);

  localparam int W  = DATA_PATH_WIDTH;
  localparam int CW = W + 8;

  cfg_t                cfg, cfg_q;
  logic                clear_fault;
  state_t              state, state_n;
  logic signed [W-1:0]  din_q, target_q, last_out, out_q;
  logic signed [CW-1:0] cal_c, cal_q, lo_x, hi_x, sat_val;
  logic                 sat_flag, trip;
  logic [7:0]           rep_left, fcnt, fcnt_n;

  dac_processing_cu u_cu (
    .clock, .reset,
    .awaddr(axi_in_awaddr), .awvalid(axi_in_awvalid), .awready(axi_in_awready),
    .wdata(axi_in_wdata), .wvalid(axi_in_wvalid), .wready(axi_in_wready),
    .bresp(axi_in_bresp), .bvalid(axi_in_bvalid), .bready(axi_in_bready),
    .araddr(axi_in_araddr), .arvalid(axi_in_arvalid), .arready(axi_in_arready),
    .rdata(axi_in_rdata), .rresp(axi_in_rresp), .rvalid(axi_in_rvalid),
    .rready(axi_in_rready), .cfg, .clear_fault
  );

  // Next emitted value: either jump to target or move toward it by at most slew_step.
  function automatic logic signed [W-1:0] slew_next(input logic signed [W-1:0] prev,
                                                    input logic signed [W-1:0] tgt,
                                                    input cfg_t c);
    logic signed [W+1:0] diff, lim;
    diff = (W+2)'(tgt) - (W+2)'(prev);
    lim  = (W+2)'(c.slew_step);
    if (diff > lim) diff = lim;
    else if (diff < -lim) diff = -lim;
    return c.slew_enable ? W'((W+2)'(prev) + diff) : tgt;
  endfunction

  assign cal_c = ((CW)'(din_q) + (CW)'(cfg_q.offset)) <<< cfg_q.cal_shift;
  assign lo_x  = (CW)'(cfg_q.lim_low);
  assign hi_x  = (CW)'(cfg_q.lim_high);

  // An inverted window (low > high) always resolves to lim_low.
  always_comb begin
    sat_val  = cal_q;
    sat_flag = 1'b0;
    if (cal_q < lo_x) begin
      sat_val  = lo_x;
      sat_flag = 1'b1;
    end else if (cal_q > hi_x) begin
      sat_val  = (lo_x > hi_x) ? lo_x : hi_x;
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (data_in_valid && data_in_ready) state_n = CAL;
      CAL:     state_n = SAT;
      SAT:     state_n = EMIT;
      EMIT:    if (data_out_ready && rep_left == 8'd1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign data_out_valid = (state == EMIT);
  assign data_out_data  = out_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      data_in_ready <= 1'b0;
      din_q         <= '0;
      cfg_q         <= CFG_RESET;
      cal_q         <= '0;
      target_q      <= '0;
      out_q         <= '0;
      last_out      <= '0;
      rep_left      <= '0;
    end else begin
      state         <= state_n;
      data_in_ready <= (state_n == IDLE);
      case (state)
        IDLE: if (data_in_valid && data_in_ready) begin
          din_q    <= data_in_data;
          cfg_q    <= cfg;
          rep_left <= (cfg.interp_ratio == 8'd0) ? 8'd1 : cfg.interp_ratio;
        end
        CAL: cal_q <= cal_c;
        SAT: begin
          target_q <= W'(sat_val);
          out_q    <= slew_next(last_out, W'(sat_val), cfg_q);
        end
        EMIT: if (data_out_ready) begin
          last_out <= out_q;
          rep_left <= rep_left - 8'd1;
          out_q    <= slew_next(out_q, target_q, cfg_q);
        end
        default: ;
      endcase
    end
  end

  assign fcnt_n = !sat_flag ? 8'd0 : (fcnt == 8'hFF) ? 8'hFF : fcnt + 8'd1;
  assign trip   = sat_flag && (fcnt_n > cfg_q.fault_delay);

  // Counter advances once per sample, in SAT; a clear racing a trip still leaves fault set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fcnt  <= '0;
      fault <= 1'b0;
    end else if (cfg.fault_disable) begin
      fcnt  <= '0;
      fault <= 1'b0;
    end else if (state == SAT) begin
      fcnt <= clear_fault ? 8'd0 : fcnt_n;
      if (STICKY_FAULT) fault <= trip || (fault && !clear_fault);
      else              fault <= trip;
    end else if (clear_fault) begin
      fcnt <= '0;
      if (STICKY_FAULT) fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_processing.sv
// Self-checking bench: a non-sticky and a sticky instance driven in lockstep, scoreboarded outputs.
module tb_dac_processing;
  localparam int W = 16;

  logic clock = 1'b0, reset = 1'b0;
  always #5 clock = ~clock;

  logic                in_valid = 1'b0, out_ready = 1'b1;
  logic signed [W-1:0] in_data = '0;
  logic [3:0]          awaddr = '0, araddr = '0;
  logic [31:0]         wdata = '0;
  logic                awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic                bready = 1'b1, rready = 1'b1;

  logic                in_ready, out_valid, awready, wready, bvalid, arready, rvalid, fault0;
  logic signed [W-1:0] out_data;
  logic [1:0]          bresp, rresp;
  logic [31:0]         rdata;
  logic                in_ready1, out_valid1, awready1, wready1, bvalid1, arready1, rvalid1, fault1;
  logic signed [W-1:0] out_data1;
  logic [1:0]          bresp1, rresp1;
  logic [31:0]         rdata1;

  dac_processing #(.DATA_PATH_WIDTH(W), .STICKY_FAULT(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .data_in_valid(in_valid), .data_in_ready(in_ready), .data_in_data(in_data),
    .data_out_valid(out_valid), .data_out_ready(out_ready), .data_out_data(out_data),
    .axi_in_awaddr(awaddr), .axi_in_awvalid(awvalid), .axi_in_awready(awready),
    .axi_in_wdata(wdata), .axi_in_wvalid(wvalid), .axi_in_wready(wready),
    .axi_in_bresp(bresp), .axi_in_bvalid(bvalid), .axi_in_bready(bready),
    .axi_in_araddr(araddr), .axi_in_arvalid(arvalid), .axi_in_arready(arready),
    .axi_in_rdata(rdata), .axi_in_rresp(rresp), .axi_in_rvalid(rvalid),
    .axi_in_rready(rready), .fault(fault0));

  dac_processing #(.DATA_PATH_WIDTH(W), .STICKY_FAULT(1'b1)) dut1 (
    .clock(clock), .reset(reset),
    .data_in_valid(in_valid), .data_in_ready(in_ready1), .data_in_data(in_data),
    .data_out_valid(out_valid1), .data_out_ready(out_ready), .data_out_data(out_data1),
    .axi_in_awaddr(awaddr), .axi_in_awvalid(awvalid), .axi_in_awready(awready1),
    .axi_in_wdata(wdata), .axi_in_wvalid(wvalid), .axi_in_wready(wready1),
    .axi_in_bresp(bresp1), .axi_in_bvalid(bvalid1), .axi_in_bready(bready),
    .axi_in_araddr(araddr), .axi_in_arvalid(arvalid), .axi_in_arready(arready1),
    .axi_in_rdata(rdata1), .axi_in_rresp(rresp1), .axi_in_rvalid(rvalid1),
    .axi_in_rready(rready), .fault(fault1));

  int nvec = 0, nerr = 0;
  logic signed [W-1:0] exp_q[$];

  typedef struct {
    logic signed [15:0] lo, hi, off;
    logic [2:0]         sh;
    logic signed [15:0] din, exp_out;
    logic               exp_sat;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: an output handshake happens at the posedge following this sample.
  always @(negedge clock) begin
    logic signed [W-1:0] e;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out: got %0d, expected no output", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e);
        check("out_data_sticky_inst", out_data1, e);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!awready && n < 20) begin tick(); n++; end
    if (n == 20) begin nvec++; nerr++; $display("FAIL axi_write_timeout: got no awready, expected awready"); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    #1;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (n == 20) begin nvec++; nerr++; $display("FAIL axi_read_timeout: got no rvalid, expected rvalid"); end
    d = rdata;
  endtask

  // Returns the number of clock cycles from the input handshake cycle to the first output valid.
  task automatic send(input logic signed [W-1:0] d, output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n == 50) begin nvec++; nerr++; $display("FAIL send_timeout: got ready=0, expected ready=1"); end
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clock); n++; end
    lat = n;
  endtask

  task automatic drain();
    int n = 0;
    tick();
    while (exp_q.size() != 0 && n < 100) begin tick(); n++; end
    check("drain_queue_empty", exp_q.size(), 0);
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
  endtask

  initial begin
    int lat;
    logic bad;
    logic signed [W-1:0] hold;
    logic [31:0] rd;

    vt[0] = '{16'sh8000, 16'sh7FFF, 16'sd0,    3'd0, 16'sd1000,  16'sd1000,  1'b0};
    vt[1] = '{16'sh8000, 16'sd3000, -16'sd100, 3'd2, 16'sd900,   16'sd3000,  1'b1};
    vt[2] = '{16'sh8000, 16'sd3000, -16'sd100, 3'd2, 16'sd100,   16'sd0,     1'b0};
    vt[3] = '{-16'sd500, 16'sd500,  16'sd0,    3'd0, -16'sd1000, -16'sd500,  1'b1};
    vt[4] = '{-16'sd500, 16'sd500,  16'sd0,    3'd0, 16'sd500,   16'sd500,   1'b0};
    vt[5] = '{16'sd100,  -16'sd100, 16'sd0,    3'd0, 16'sd0,     16'sd100,   1'b1};
    vt[6] = '{16'sh8000, 16'sh7FFF, 16'sd0,    3'd7, 16'sh7FFF,  16'sh7FFF,  1'b1};
    vt[7] = '{16'sh8000, 16'sh7FFF, 16'sh8000, 3'd7, 16'sh8000,  16'sh8000,  1'b1};
    vt[8] = '{16'sh8000, 16'sh7FFF, 16'sd5,    3'd3, -16'sd7,    -16'sd16,   1'b0};

    // Reset state
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fault", fault0, 0);
    reset = 1'b1;
    tick();
    check("ready_first_edge", in_ready, 1);
    axi_read(4'h0, rd); check("rd_lim_default", rd, 32'h7FFF8000);
    axi_read(4'hC, rd); check("rd_ctrl_default", rd, 32'h0000_0001);

    // Table: single-shot calibration/clamp vectors
    for (int i = 0; i < 9; i++) begin
      axi_write(4'h0, {vt[i].hi, vt[i].lo});
      axi_write(4'h4, {13'd0, vt[i].sh, vt[i].off});
      exp_q.push_back(vt[i].exp_out);
      send(vt[i].din, lat);
      if (i == 0) check("first_valid_latency", lat, 3);
      drain();
      check("vec_fault", fault0, vt[i].exp_sat);
    end

    // Backpressure mid-EMIT
    axi_write(4'h0, 32'h7FFF8000);
    axi_write(4'h4, 32'h0);
    axi_write(4'hC, 32'h3);
    repeat (3) exp_q.push_back(16'sd700);
    send(16'sd700, lat);
    tick();
    out_ready = 1'b0;
    hold = out_data; bad = 1'b0;
    repeat (10) begin
      tick();
      if (!out_valid || out_data !== hold || in_ready) bad = 1'b1;
    end
    check("bp_stable", bad, 0);
    check("bp_pending", exp_q.size(), 2);
    out_ready = 1'b1;
    drain();

    // Fault delay 2: sticky vs non-sticky
    axi_write(4'h0, {16'd500, 16'hFE0C});
    axi_write(4'hC, 32'h0001_0201);
    tick(); tick();
    check("sticky_cleared", fault1, 0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(16'sd500);
      send(16'sd1000, lat);
      drain();
      check("sticky_trip", fault1, (k == 2));
      check("nonsticky_trip", fault0, (k == 2));
    end
    exp_q.push_back(16'sd0);
    send(16'sd0, lat);
    drain();
    check("sticky_hold", fault1, 1);
    check("nonsticky_drop", fault0, 0);
    axi_write(4'hC, 32'h0001_0201);
    tick(); tick();
    check("sticky_clear", fault1, 0);
    axi_read(4'hC, rd); check("rd_ctrl_pulse_bit", rd, 32'h0000_0201);

    // fault_disable masks a saturated sample
    axi_write(4'hC, 32'h0002_0001);
    exp_q.push_back(16'sd500);
    send(16'sd1000, lat);
    drain();
    check("disable_fault0", fault0, 0);
    check("disable_fault1", fault1, 0);

    // Async reset mid-EMIT: held-off output, fault set, then reset with no edge
    axi_write(4'hC, 32'h0000_0004);
    out_ready = 1'b0;
    send(16'sd1234, lat);
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_fault", fault0, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 0);
    check("async_rst_fault", fault0, 0);
    check("async_rst_fault_sticky", fault1, 0);
    tick(); tick();
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    check("ready_after_rst", in_ready, 1);

    // Slew with interpolation starting from last_out = 0
    axi_write(4'h8, 32'd50);
    axi_write(4'hC, 32'h0004_0004);
    exp_q.push_back(16'sd50); exp_q.push_back(16'sd100);
    exp_q.push_back(16'sd120); exp_q.push_back(16'sd120);
    send(16'sd120, lat);
    bad = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      tick();
      if (exp_q.size() != 0 && in_ready) bad = 1'b1;
    end
    check("slew_ready_low", bad, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
